// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: flow-control opcodes and the
// next-address source selector used by the PC mux.
package fetch_ctrl_pkg;

  localparam int OP_JZ   = 5;
  localparam int OP_JMP  = 6;
  localparam int OP_CALL = 7;
  localparam int OP_RET  = 8;
  localparam int OP_RETI = 9;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_POP,
    SRC_BRANCH,
    SRC_ITR,
    SRC_SEQ
  } addr_src_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack with combinational top-of-stack read and sticky
// overflow/underflow flags; a dropped push or an empty pop leaves sp untouched.
module ret_stack #(
  parameter int MINSTW = 8,
  parameter int SDEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [MINSTW-1:0] din,
  output logic [MINSTW-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int AW = $clog2(SDEPTH);

  // sp is one bit wider than the index so that a full stack is representable
  logic [AW:0]       sp;
  logic [AW:0]       sp_dec;
  logic [MINSTW-1:0] mem [SDEPTH];

  assign full   = (sp == (AW+1)'(SDEPTH));
  assign empty  = (sp == '0);
  assign sp_dec = sp - (AW+1)'(1);
  assign dout   = empty ? '0 : mem[sp_dec[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push) begin
      if (full) ovf <= 1'b1;
      else      sp  <= sp + (AW+1)'(1);
    end else if (pop) begin
      if (empty) unf <= 1'b1;
      else       sp  <= sp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[sp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, decodes flow control, keeps the
// return stack and arbitrates edge-triggered vectored interrupts.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int MINSTW  = 8,
  parameter int NBOPCO  = 6,
  parameter int NBOPER  = 9,
  parameter int SDEPTH  = 8,
  parameter int NITR    = 4,
  parameter int ITRBASE = 1,
  parameter int ITRSTEP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBOPCO+NBOPER-1:0] instr,
  input  logic                     acc_is_zero,
  input  logic                     stall,
  input  logic [NITR-1:0]          itr,
  output logic [NBOPCO-1:0]        opcode,
  output logic [NBOPER-1:0]        operand,
  output logic [MINSTW-1:0]        instr_addr,
  output logic [MINSTW-1:0]        pc,
  output logic [NITR-1:0]          itr_ack,
  output logic                     in_isr,
  output logic                     stk_ovf,
  output logic                     stk_unf
);

  addr_src_e         src;
  logic [NITR-1:0]   itr_q;
  logic [NITR-1:0]   pend;
  logic [NITR-1:0]   first_oh;
  logic [MINSTW-1:0] vec;
  logic [MINSTW-1:0] pc_inc;
  logic [MINSTW-1:0] next_addr;
  logic [MINSTW-1:0] stk_top;
  logic              is_ret, is_reti, is_call, is_br;
  logic              push, pop;
  logic              stk_full_unused, stk_empty_unused;

  assign opcode  = instr[NBOPCO+NBOPER-1:NBOPER];
  assign operand = instr[NBOPER-1:0];
  assign pc_inc  = pc + MINSTW'(1);

  assign is_reti = (opcode == NBOPCO'(OP_RETI));
  assign is_ret  = (opcode == NBOPCO'(OP_RET)) || is_reti;
  assign is_call = (opcode == NBOPCO'(OP_CALL));
  assign is_br   = (opcode == NBOPCO'(OP_JMP)) || is_call ||
                   ((opcode == NBOPCO'(OP_JZ)) && acc_is_zero);

  // Interrupts only win when no flow control is in flight, so a request
  // arriving alongside a branch simply waits in pend.
  always_comb begin
    src = SRC_SEQ;
    if (stall)                    src = SRC_HOLD;
    else if (is_ret)              src = SRC_POP;
    else if (is_br)               src = SRC_BRANCH;
    else if (|pend && !in_isr)    src = SRC_ITR;
  end

  // Walk from the top down so the lowest pending channel is the one kept
  always_comb begin
    first_oh = '0;
    vec      = '0;
    for (int i = NITR - 1; i >= 0; i--) begin
      if (pend[i]) begin
        first_oh    = '0;
        first_oh[i] = 1'b1;
        vec         = MINSTW'(ITRBASE + i * ITRSTEP);
      end
    end
  end

  always_comb begin
    next_addr = pc_inc;
    case (src)
      SRC_HOLD:   next_addr = pc;
      SRC_POP:    next_addr = stk_top;
      SRC_BRANCH: next_addr = operand[MINSTW-1:0];
      SRC_ITR:    next_addr = vec;
      default:    next_addr = pc_inc;
    endcase
  end

  assign instr_addr = rst ? next_addr : '0;
  assign itr_ack    = (src == SRC_ITR) ? first_oh : '0;
  assign push       = (src == SRC_ITR) || ((src == SRC_BRANCH) && is_call);
  assign pop        = (src == SRC_POP);

  ret_stack #(
    .MINSTW (MINSTW),
    .SDEPTH (SDEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full_unused),
    .empty (stk_empty_unused),
    .ovf   (stk_ovf),
    .unf   (stk_unf)
  );

  // An edge arriving in the take cycle re-arms its own channel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= '0;
      itr_q  <= '0;
      pend   <= '0;
      in_isr <= 1'b0;
    end else begin
      pc    <= next_addr;
      itr_q <= itr;
      pend  <= (pend & ~itr_ack) | (itr & ~itr_q);
      if (src == SRC_ITR)                in_isr <= 1'b1;
      else if ((src == SRC_POP) && is_reti) in_isr <= 1'b0;
    end
  end

endmodule
